// File: rtl/adc_stream_packetizer.sv
// ADC channel capture engine: packs SAMPLE_W samples into TDATA_W AXI-Stream beats with tlast framing.
// Optional macro ADC_TEST_PATTERN_EN adds a test_mode input that substitutes a ramp counter for ADC data.
module adc_stream_packetizer #(
  parameter int SAMPLE_W   = 16,
  parameter int NUM_CH     = 2,
  parameter int TDATA_W    = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                       test_mode,
`endif
  input  logic                       start,
  input  logic                       stop,
  input  logic [CH_W-1:0]            ch_sel,
  input  logic [CNT_W-1:0]           pkt_size,
  input  logic [CNT_W-1:0]           pkt_count,
  input  logic                       s_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] s_data,
  output logic [TDATA_W-1:0]         m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic                       cfg_err
);

  localparam int SPB   = TDATA_W / SAMPLE_W;
  localparam int BYTES = TDATA_W / 8;
  localparam int IDX_W = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;
  state_t state, state_n;

  logic [CH_W-1:0]     ch_q;
  logic [CNT_W-1:0]    bpp_q, pkt_count_q, beat_cnt, pkt_cnt;
  logic                stop_q;
  logic [IDX_W-1:0]    samp_idx;
  logic [TDATA_W-1:0]  packer, beat_data;
  logic [SAMPLE_W-1:0] sel_sample, sample;
  logic                overflow_q, done_q, cfg_err_q;
  logic [CH_W:0]       ch_ext;

  logic [TDATA_W:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;

  logic full, pop, push, drop, complete, beat_last, cfg_bad, start_ok, stop_req, flush_ok, run_end;

  always_comb begin
    sel_sample = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      if (CH_W'(k) == ch_q) sel_sample = s_data[k*SAMPLE_W +: SAMPLE_W];
  end

`ifdef ADC_TEST_PATTERN_EN
  logic                test_q;
  logic [SAMPLE_W-1:0] pat_cnt;

  assign sample = test_q ? pat_cnt : sel_sample;

  always_ff @(posedge clk) begin
    if (reset) begin
      test_q  <= 1'b0;
      pat_cnt <= '0;
    end else if (start_ok) begin
      test_q  <= test_mode;
      pat_cnt <= '0;
    end else if (state == CAPTURE && s_valid) begin
      pat_cnt <= pat_cnt + 1'b1;
    end
  end
`else
  assign sample = sel_sample;
`endif

  // The completing sample is merged combinationally so the beat is pushed in the same cycle.
  always_comb begin
    beat_data = packer;
    for (int unsigned i = 0; i < SPB; i++)
      if (IDX_W'(i) == samp_idx) beat_data[i*SAMPLE_W +: SAMPLE_W] = sample;
  end

  always_comb begin
    ch_ext  = {1'b0, ch_sel};
    cfg_bad = (pkt_size == '0) || ((pkt_size % CNT_W'(BYTES)) != '0) ||
              (ch_ext >= (CH_W+1)'(NUM_CH));
  end

  always_comb begin
    m_tvalid = (count != '0);
    m_tdata  = '0;
    m_tlast  = 1'b0;
    if (m_tvalid) begin
      m_tdata = mem[rd_ptr][TDATA_W-1:0];
      m_tlast = mem[rd_ptr][TDATA_W];
    end
  end

  always_comb begin
    state_n   = state;
    start_ok  = 1'b0;
    full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    pop       = m_tvalid && m_tready;
    stop_req  = stop_q || stop;
    flush_ok  = (count == '0) || ((count == (PTR_W+1)'(1)) && pop);
    complete  = (state == CAPTURE) && s_valid && (samp_idx == IDX_W'(SPB-1));
    push      = complete && (!full || pop);
    drop      = complete && full && !pop;
    beat_last = (beat_cnt == bpp_q - 1'b1);
    run_end   = (pkt_count_q != '0) && (pkt_cnt + 1'b1 == pkt_count_q);
    case (state)
      IDLE: begin
        if (start && !cfg_bad) begin
          start_ok = 1'b1;
          state_n  = CAPTURE;
        end
      end
      CAPTURE: begin
        // Leave only on a packet boundary: after a pushed tlast beat, or at once if nothing is in flight.
        if (push && beat_last && (stop_req || run_end))
          state_n = FLUSH;
        else if (stop_req && !complete && beat_cnt == '0 && samp_idx == '0)
          state_n = FLUSH;
      end
      FLUSH: begin
        if (flush_ok) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q        <= '0;
      bpp_q       <= '0;
      pkt_count_q <= '0;
      beat_cnt    <= '0;
      pkt_cnt     <= '0;
      samp_idx    <= '0;
      packer      <= '0;
      stop_q      <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= (state == FLUSH) && flush_ok;
      cfg_err_q <= (state == IDLE) && start && cfg_bad;
      if (state == IDLE)                 stop_q <= 1'b0;
      else if (state == CAPTURE && stop) stop_q <= 1'b1;
      if (start_ok) begin
        ch_q        <= ch_sel;
        bpp_q       <= pkt_size / CNT_W'(BYTES);
        pkt_count_q <= pkt_count;
        beat_cnt    <= '0;
        pkt_cnt     <= '0;
        samp_idx    <= '0;
        overflow_q  <= 1'b0;
      end else if (state == CAPTURE && s_valid) begin
        packer   <= beat_data;
        samp_idx <= complete ? '0 : samp_idx + 1'b1;
        if (push) begin
          beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
          if (beat_last) pkt_cnt <= pkt_cnt + 1'b1;
        end
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {beat_last, beat_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign cfg_err  = cfg_err_q;

endmodule
